mult8_seq_ctrl: RTL and testbench

//  Sequencer for the 8x8 multiplier built from one shared 4x4 nibble multiplier.

---
 rtl/mult8_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult8_seq_ctrl
// Sequencer for an 8x8 unsigned multiplier built from one shared 4x4 nibble
// multiplier. Operands are split into nibbles and the four partial products
// are aligned and accumulated into 16 bits, one per cycle.
//
// Build option:
//   MULT8_ZERO_SKIP_EN  when defined, a zero operand at start goes straight to
//                       DONE with product 0 (done one cycle after start).
//
// Parameters:
//   PIPE_PP   0: accumulate the aligned partial product directly
//             1: register the aligned partial product first (+1 cycle)
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   multiply request, sampled in IDLE or DONE
//   a        in   8   multiplicand, captured on accepted start
//   b        in   8   multiplier, captured on accepted start
//   busy     out  1   partial products being accumulated
//   done     out  1   one-cycle product-valid pulse
//   product  out 16   result, held until the next DONE entry
//   pp_sel   out  2   current partial-product select (00 outside CALC)
//
// state | meaning
// IDLE  | waiting for start
// CALC  | stepping pp_sel 00..11 (plus one drain cycle when PIPE_PP=1)
// DONE  | done pulse; product valid; start accepted for back-to-back ops
// -----------------------------------------------------------------------------
module mult8_seq_ctrl #(
  parameter bit PIPE_PP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [1:0]  pp_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic [15:0] pipe_q, pipe_d;

  logic [3:0]  op_x, op_y;
  logic [7:0]  nib;
  logic [15:0] pp_aligned;
  logic [15:0] acc_sum;

  // Shared nibble multiplier: pp_sel[0] picks the a nibble, pp_sel[1] the b nibble.
  always_comb begin
    op_x = cnt_q[0] ? a_q[7:4] : a_q[3:0];
    op_y = cnt_q[1] ? b_q[7:4] : b_q[3:0];
    nib  = {4'h0, op_x} * {4'h0, op_y};
    case (cnt_q)
      2'b00:   pp_aligned = {8'h00, nib};
      2'b11:   pp_aligned = {nib, 8'h00};
      default: pp_aligned = {4'h0, nib, 4'h0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    pipe_d  = pipe_q;
    acc_sum = 16'h0000;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
          cnt_d   = 2'b00;
          drain_d = 1'b0;
          pipe_d  = 16'h0000;
`ifdef MULT8_ZERO_SKIP_EN
          if ((a == 8'h00) || (b == 8'h00)) begin
            state_d = DONE;
            prod_d  = 16'h0000;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (!PIPE_PP) begin
          acc_sum = acc_q + pp_aligned;
          acc_d   = acc_sum;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'b11) begin
            state_d = DONE;
            prod_d  = acc_sum;
          end
        end else begin
          // pipe_q starts at zero, so the first accumulate adds nothing.
          acc_sum = acc_q + pipe_q;
          acc_d   = acc_sum;
          if (!drain_q) begin
            pipe_d = pp_aligned;
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'b11) drain_d = 1'b1;
          end else begin
            state_d = DONE;
            prod_d  = acc_sum;
            drain_d = 1'b0;
            pipe_d  = 16'h0000;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      prod_q  <= 16'h0000;
      cnt_q   <= 2'b00;
      drain_q <= 1'b0;
      pipe_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      pipe_q  <= pipe_d;
    end
  end

  // The counter wraps to 00 before the drain cycle, so pp_sel reads 00 there.
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;
  assign pp_sel  = (state_q == CALC) ? cnt_q : 2'b00;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult8_seq_ctrl
// Drives two instances (PIPE_PP=0 and PIPE_PP=1) with the same stimulus and
// compares every cycle against expectations derived from a*b and the
// documented latencies.
// -----------------------------------------------------------------------------
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy_o [2];
  logic        done_o [2];
  logic [15:0] prod_o [2];
  logic [1:0]  sel_o  [2];

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_prod [2];

  mult8_seq_ctrl #(.PIPE_PP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_o[0]), .done(done_o[0]), .product(prod_o[0]), .pp_sel(sel_o[0])
  );

  mult8_seq_ctrl #(.PIPE_PP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_o[1]), .done(done_o[1]), .product(prod_o[1]), .pp_sel(sel_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int norm_lat(input int d);
    return (d == 0) ? 5 : 6;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 || prod_o[d] !== 16'h0000 || sel_o[d] !== 2'b00) begin
        failures++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b product=%h pp_sel=%b, required 0/0/0000/00",
                 d, busy_o[d], done_o[d], prod_o[d], sel_o[d]);
      end
      prev_prod[d] = 16'h0000;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated multiply: start for one cycle, then scramble a/b while busy.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
    logic [15:0] ref_p;
    bit skip;
    ref_p = 16'(ta) * 16'(tb_v);
`ifdef MULT8_ZERO_SKIP_EN
    skip = (ta == 8'h00) || (tb_v == 8'h00);
`else
    skip = 1'b0;
`endif
    start = 1'b1; a = ta; b = tb_v;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      for (int d = 0; d < 2; d++) begin
        int L;
        logic        e_done, e_busy;
        logic [1:0]  e_sel;
        logic [15:0] e_prod;
        L      = skip ? 1 : norm_lat(d);
        e_done = (c == L);
        e_busy = !skip && (c < L);
        e_sel  = (!skip && c <= 4) ? 2'(c - 1) : 2'b00;
        e_prod = (c >= L) ? ref_p : prev_prod[d];
        checks++;
        if (done_o[d] !== e_done || busy_o[d] !== e_busy) begin
          failures++;
          $display("FAIL %s_ctrl dut%0d cyc%0d a=%h b=%h: busy=%b done=%b, required busy=%b done=%b",
                   tag, d, c, ta, tb_v, busy_o[d], done_o[d], e_busy, e_done);
        end
        checks++;
        if (sel_o[d] !== e_sel) begin
          failures++;
          $display("FAIL %s_pp_sel dut%0d cyc%0d: got %b, required %b", tag, d, c, sel_o[d], e_sel);
        end
        checks++;
        if (prod_o[d] !== e_prod) begin
          failures++;
          $display("FAIL %s_product dut%0d cyc%0d a=%h b=%h: got %h, required %h",
                   tag, d, c, ta, tb_v, prod_o[d], e_prod);
        end
      end
    end
    prev_prod[0] = ref_p;
    prev_prod[1] = ref_p;
  endtask

  task automatic test_directed();
    run_op(8'h12, 8'h34, "dir_12x34");
    run_op(8'hFF, 8'hFF, "dir_ffxff");
    run_op(8'h01, 8'h01, "dir_1x1");
    run_op(8'hF0, 8'h0F, "dir_f0x0f");
  endtask

  task automatic test_zero_operand();
    run_op(8'h00, 8'h5A, "zero_a");
    run_op(8'h5A, 8'h00, "zero_b");
    run_op(8'h00, 8'h00, "zero_ab");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 17 == 0) ra = 8'h00;
      run_op(ra, rb, "rand");
    end
  endtask

  // start held high: each instance re-accepts in DONE with no idle bubble.
  task automatic test_back_to_back();
    logic [15:0] p1, p2;
    p1 = 16'd63;
    p2 = 16'd600;
    start = 1'b1; a = 8'd7; b = 8'd9;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin a = 8'd200; b = 8'd3; end
      if (c == 7) begin start = 1'b0; a = 8'h11; b = 8'h22; end
      for (int d = 0; d < 2; d++) begin
        int L;
        logic        e_done, e_busy;
        logic [15:0] e_prod;
        L      = norm_lat(d);
        e_done = (c == L) || (c == 2 * L);
        e_busy = (c < L) || (c > L && c < 2 * L);
        e_prod = (c >= 2 * L) ? p2 : ((c >= L) ? p1 : prev_prod[d]);
        checks++;
        if (done_o[d] !== e_done || busy_o[d] !== e_busy) begin
          failures++;
          $display("FAIL b2b_ctrl dut%0d cyc%0d: busy=%b done=%b, required busy=%b done=%b",
                   d, c, busy_o[d], done_o[d], e_busy, e_done);
        end
        checks++;
        if (prod_o[d] !== e_prod) begin
          failures++;
          $display("FAIL b2b_product dut%0d cyc%0d: got %h, required %h", d, c, prod_o[d], e_prod);
        end
      end
    end
    prev_prod[0] = p2;
    prev_prod[1] = p2;
  endtask

  task automatic test_reset_mid_calc();
    start = 1'b1; a = 8'hAB; b = 8'hCD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 || prod_o[d] !== 16'h0000 || sel_o[d] !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_calc dut%0d: busy=%b done=%b product=%h pp_sel=%b, required 0/0/0000/00",
                 d, busy_o[d], done_o[d], prod_o[d], sel_o[d]);
      end
      prev_prod[d] = 16'h0000;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle dut%0d: busy=%b done=%b, required 0/0", d, busy_o[d], done_o[d]);
      end
    end
    run_op(8'hAB, 8'hCD, "post_reset");
  endtask

  // busy and done must never overlap on either instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (busy_o[d] === 1'b1 && done_o[d] === 1'b1) begin
          failures++;
          $display("FAIL busy_done_overlap dut%0d: busy=%b done=%b, required not both 1",
                   d, busy_o[d], done_o[d]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_directed();
    test_zero_operand();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
